// File: rtl/data_bus_arbiter_if.sv
// Master-side handshake bundle for the two-master data bus arbiter.
// The "master" modport is the requester's view; "slave" is the arbiter's view.
interface data_bus_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [1:0]  m0_mode;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_done;
    logic        m0_err;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic [1:0]  m1_mode;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_done;
    logic        m1_err;
    logic [31:0] m1_rdata;

    modport master (
        output m0_req, m0_addr, m0_mode, m0_wdata,
        input  m0_gnt, m0_done, m0_err, m0_rdata,
        output m1_req, m1_addr, m1_mode, m1_wdata,
        input  m1_gnt, m1_done, m1_err, m1_rdata
    );

    modport slave (
        input  m0_req, m0_addr, m0_mode, m0_wdata,
        output m0_gnt, m0_done, m0_err, m0_rdata,
        input  m1_req, m1_addr, m1_mode, m1_wdata,
        output m1_gnt, m1_done, m1_err, m1_rdata
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter/sequencer for the shared peripheral data bus.
// Master 0 has fixed priority; master 1 is guaranteed a grant after
// MAX_CONSEC consecutive master-0 grants while it is waiting.
// Each transfer runs IDLE -> ACCESS -> RESP, one cycle per state.
module data_bus_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    data_bus_arbiter_if.slave  mst,
    output logic [31:0]        data_bus_addr,
    output logic [1:0]         data_bus_mode,
    inout  wire  [31:0]        data_bus_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CONSEC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Only genuine reads and writes reach the bus; none/illegal look idle.
    function automatic logic [1:0] bus_mode_of(input logic [1:0] mode);
        logic [1:0] result;
        case (mode)
            2'b01:   result = 2'b01;
            2'b10:   result = 2'b10;
            default: result = 2'b00;
        endcase
        return result;
    endfunction

    state_t            state_r;
    logic              sel_r;
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              drv_en_r;
    logic [31:0]       wdata_r;
    logic [31:0]       data_bus_addr_r;
    logic [1:0]        data_bus_mode_r;
    logic              busy_r;

    logic              m0_gnt_r;
    logic              m0_done_r;
    logic              m0_err_r;
    logic [31:0]       m0_rdata_r;
    logic              m1_gnt_r;
    logic              m1_done_r;
    logic              m1_err_r;
    logic [31:0]       m1_rdata_r;

    logic              grant_any_s;
    logic              grant_m1_s;
    logic [31:0]       win_addr_s;
    logic [1:0]        win_mode_s;
    logic [31:0]       win_wdata_s;

    // Arbitration: pick the winner from the currently sampled requests.
    always_comb begin
        grant_any_s = mst.m0_req | mst.m1_req;
        if (mst.m0_req && mst.m1_req) begin
            grant_m1_s = (cnt_r == MAX_CNT);
        end else if (mst.m1_req) begin
            grant_m1_s = 1'b1;
        end else begin
            grant_m1_s = 1'b0;
        end
        if (grant_m1_s) begin
            win_addr_s  = mst.m1_addr;
            win_mode_s  = mst.m1_mode;
            win_wdata_s = mst.m1_wdata;
        end else begin
            win_addr_s  = mst.m0_addr;
            win_mode_s  = mst.m0_mode;
            win_wdata_s = mst.m0_wdata;
        end
    end

    // Transfer sequencer: grant, one bus access cycle, one response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            sel_r           <= 1'b0;
            mode_r          <= 2'b00;
            cnt_r           <= '0;
            drv_en_r        <= 1'b0;
            wdata_r         <= 32'h0000_0000;
            data_bus_addr_r <= 32'h0000_0000;
            data_bus_mode_r <= 2'b00;
            busy_r          <= 1'b0;
            m0_gnt_r        <= 1'b0;
            m0_done_r       <= 1'b0;
            m0_err_r        <= 1'b0;
            m0_rdata_r      <= 32'h0000_0000;
            m1_gnt_r        <= 1'b0;
            m1_done_r       <= 1'b0;
            m1_err_r        <= 1'b0;
            m1_rdata_r      <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_any_s) begin
                        sel_r           <= grant_m1_s;
                        mode_r          <= win_mode_s;
                        wdata_r         <= win_wdata_s;
                        data_bus_addr_r <= win_addr_s;
                        data_bus_mode_r <= bus_mode_of(win_mode_s);
                        drv_en_r        <= (win_mode_s == 2'b10);
                        m0_gnt_r        <= ~grant_m1_s;
                        m1_gnt_r        <= grant_m1_s;
                        busy_r          <= 1'b1;
                        // Starvation guard: count m0 wins only while m1 waits.
                        if (grant_m1_s || !mst.m1_req) begin
                            cnt_r <= '0;
                        end else if (cnt_r < MAX_CNT) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Capture read data at the closing edge of the access.
                    if (mode_r == 2'b01) begin
                        if (sel_r) begin
                            m1_rdata_r <= data_bus_data;
                        end else begin
                            m0_rdata_r <= data_bus_data;
                        end
                    end
                    data_bus_addr_r <= 32'h0000_0000;
                    data_bus_mode_r <= 2'b00;
                    drv_en_r        <= 1'b0;
                    if (sel_r) begin
                        m1_done_r <= 1'b1;
                        m1_err_r  <= (mode_r == 2'b11);
                    end else begin
                        m0_done_r <= 1'b1;
                        m0_err_r  <= (mode_r == 2'b11);
                    end
                    state_r <= RESP;
                end
                RESP: begin
                    m0_done_r <= 1'b0;
                    m0_err_r  <= 1'b0;
                    m1_done_r <= 1'b0;
                    m1_err_r  <= 1'b0;
                    m0_gnt_r  <= 1'b0;
                    m1_gnt_r  <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r         <= IDLE;
                    data_bus_mode_r <= 2'b00;
                    drv_en_r        <= 1'b0;
                    m0_gnt_r        <= 1'b0;
                    m1_gnt_r        <= 1'b0;
                    busy_r          <= 1'b0;
                end
            endcase
        end
    end

    // The enable is a register, so the bus is released the instant reset hits.
    assign data_bus_data = drv_en_r ? wdata_r : 32'hzzzz_zzzz;

    assign data_bus_addr = data_bus_addr_r;
    assign data_bus_mode = data_bus_mode_r;
    assign busy          = busy_r;

    assign mst.m0_gnt   = m0_gnt_r;
    assign mst.m0_done  = m0_done_r;
    assign mst.m0_err   = m0_err_r;
    assign mst.m0_rdata = m0_rdata_r;
    assign mst.m1_gnt   = m1_gnt_r;
    assign mst.m1_done  = m1_done_r;
    assign mst.m1_err   = m1_err_r;
    assign mst.m1_rdata = m1_rdata_r;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomised scoreboard bench for data_bus_arbiter with a 16-word bus slave.
module tb_data_bus_arbiter;
    localparam int MAX_CONSEC = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_bus_arbiter_if bus_if();
    logic [31:0] data_bus_addr;
    logic [1:0]  data_bus_mode;
    wire  [31:0] data_bus_data;
    logic        busy;

    data_bus_arbiter #(.MAX_CONSEC(MAX_CONSEC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mst(bus_if),
        .data_bus_addr(data_bus_addr), .data_bus_mode(data_bus_mode),
        .data_bus_data(data_bus_data), .busy(busy)
    );

    typedef struct { logic [31:0] addr; logic [1:0] mode; logic [31:0] wdata; int gap; } txn_t;
    typedef struct { logic [31:0] rdata; logic err; int edge_no; } exp_t;

    txn_t        drv_q [2][$];
    exp_t        exp_q [2][$];
    int          obs_q [$];
    logic        req_v [2];
    logic [31:0] addr_v [2];
    logic [1:0]  mode_v [2];
    logic [31:0] wdata_v [2];
    bit          active [2];
    int          wait_cnt [2];
    int          checks = 0;
    int          fails = 0;
    int          edge_n = 0;
    bit          model_en = 1'b0;
    int          free_at = 0;
    int          cnt_m = 0;
    logic [31:0] last_rd [2];
    logic [31:0] ref_mem [16];
    logic [31:0] slave_mem [16];

    assign bus_if.m0_req   = req_v[0];
    assign bus_if.m0_addr  = addr_v[0];
    assign bus_if.m0_mode  = mode_v[0];
    assign bus_if.m0_wdata = wdata_v[0];
    assign bus_if.m1_req   = req_v[1];
    assign bus_if.m1_addr  = addr_v[1];
    assign bus_if.m1_mode  = mode_v[1];
    assign bus_if.m1_wdata = wdata_v[1];

    // Bus slave: drives read data during a read access.
    assign data_bus_data = (data_bus_mode == 2'b01) ? slave_mem[data_bus_addr[5:2]] : 32'hzzzz_zzzz;

    function automatic logic [31:0] init_val(input int k);
        return 32'hC0DE_0000 | 32'(k);
    endfunction
    function automatic txn_t mk(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d, input int g);
        txn_t t;
        t.addr = a; t.mode = m; t.wdata = d; t.gap = g;
        return t;
    endfunction
    function automatic logic done_of(input int i);
        return (i == 0) ? bus_if.m0_done : bus_if.m1_done;
    endfunction
    function automatic logic gnt_of(input int i);
        return (i == 0) ? bus_if.m0_gnt : bus_if.m1_gnt;
    endfunction
    function automatic logic err_of(input int i);
        return (i == 0) ? bus_if.m0_err : bus_if.m1_err;
    endfunction
    function automatic logic [31:0] rdata_of(input int i);
        return (i == 0) ? bus_if.m0_rdata : bus_if.m1_rdata;
    endfunction
    // Undriven bus: z in four-state simulators, 0 where z is not modelled.
    function automatic logic bus_quiet();
        return (data_bus_data === 32'hzzzz_zzzz) || (data_bus_data == 32'h0000_0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Slave write port: commit bus writes on the clock edge.
    initial begin
        for (int k = 0; k < 16; k++) slave_mem[k] = init_val(k);
        forever begin
            @(posedge clk);
            if (data_bus_mode == 2'b10) slave_mem[data_bus_addr[5:2]] = data_bus_data;
        end
    end

    // Reference model: transaction-level arbitration and memory.
    initial begin
        int   w;
        exp_t e;
        for (int k = 0; k < 16; k++) ref_mem[k] = init_val(k);
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (!reset) begin
                free_at = edge_n + 1;
                cnt_m = 0;
                last_rd[0] = 32'h0; last_rd[1] = 32'h0;
                exp_q[0].delete(); exp_q[1].delete();
            end else if (model_en && edge_n >= free_at && (req_v[0] || req_v[1])) begin
                if (req_v[0] && req_v[1]) w = (cnt_m == MAX_CONSEC) ? 1 : 0;
                else w = req_v[1] ? 1 : 0;
                if (w == 1 || !req_v[1]) cnt_m = 0;
                else if (cnt_m < MAX_CONSEC) cnt_m++;
                if (mode_v[w] == 2'b01) last_rd[w] = ref_mem[addr_v[w][5:2]];
                if (mode_v[w] == 2'b10) ref_mem[addr_v[w][5:2]] = wdata_v[w];
                e.rdata = last_rd[w];
                e.err = (mode_v[w] == 2'b11);
                e.edge_no = edge_n + 1;
                exp_q[w].push_back(e);
                free_at = edge_n + 3;
            end
        end
    end

    // Master drivers: hold fields until done, back-to-back when gap is 0.
    initial begin
        txn_t t;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; addr_v[i] = 32'h0; mode_v[i] = 2'b00; wdata_v[i] = 32'h0;
            active[i] = 1'b0; wait_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    req_v[i] = 1'b0; active[i] = 1'b0; wait_cnt[i] = 0; drv_q[i].delete();
                end else if (active[i] && done_of(i)) begin
                    if (drv_q[i].size() > 0 && drv_q[i][0].gap == 0) begin
                        t = drv_q[i].pop_front();
                        addr_v[i] = t.addr; mode_v[i] = t.mode; wdata_v[i] = t.wdata;
                    end else begin
                        active[i] = 1'b0; req_v[i] = 1'b0;
                    end
                end else if (!active[i] && drv_q[i].size() > 0) begin
                    if (wait_cnt[i] >= drv_q[i][0].gap) begin
                        t = drv_q[i].pop_front();
                        addr_v[i] = t.addr; mode_v[i] = t.mode; wdata_v[i] = t.wdata;
                        req_v[i] = 1'b1; active[i] = 1'b1; wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                    end
                end
            end
        end
    end

    // Monitor: pop expectations on every done and watch bus hygiene.
    initial begin
        exp_t e;
        int   stall [2];
        stall[0] = 0; stall[1] = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int i = 0; i < 2; i++) begin
                    if (done_of(i)) begin
                        stall[i] = 0;
                        obs_q.push_back(i);
                        if (exp_q[i].size() == 0) begin
                            checks++; fails++;
                            $display("FAIL unexpected_done: m%0d done with nothing outstanding (edge %0d)", i, edge_n);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk($sformatf("m%0d_rdata", i), rdata_of(i), e.rdata);
                            chk($sformatf("m%0d_err", i), {31'b0, err_of(i)}, {31'b0, e.err});
                            chk($sformatf("m%0d_done_edge", i), 32'(edge_n), 32'(e.edge_no));
                            chk($sformatf("m%0d_gnt_at_done", i), {31'b0, gnt_of(i)}, 32'h1);
                        end
                    end else begin
                        if (req_v[i]) stall[i]++;
                        else stall[i] = 0;
                        if (stall[i] > 40) begin
                            checks++; fails++;
                            $display("FAIL m%0d_timeout: no done after 40 cycles of req", i);
                            stall[i] = 0;
                        end
                    end
                end
                chk("one_gnt", {31'b0, bus_if.m0_gnt & bus_if.m1_gnt}, 32'h0);
                chk("busy_vs_gnt", {31'b0, busy}, {31'b0, bus_if.m0_gnt | bus_if.m1_gnt});
                chk("bus_mode_legal", {31'b0, data_bus_mode == 2'b11}, 32'h0);
                if (data_bus_mode == 2'b00) chk("bus_quiet", {31'b0, bus_quiet()}, 32'h1);
            end else begin
                stall[0] = 0; stall[1] = 0;
            end
        end
    end

    task automatic wait_done(input int i, input int n, input int budget, output bit ok);
        int seen = 0;
        int t = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (done_of(i)) seen++;
        end
        ok = (seen == n);
    endtask

    task automatic drain();
        int t = 0;
        while (t < 2000 && (drv_q[0].size() != 0 || drv_q[1].size() != 0 || active[0] || active[1] ||
                            exp_q[0].size() != 0 || exp_q[1].size() != 0)) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t < 2000), 32'h1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit ok;
        int t;
        int ed [3];
        bit saw_m0;
        int exp_order [7];
        exp_order = '{0, 0, 0, 0, 1, 0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_m0_gnt", {31'b0, bus_if.m0_gnt}, 32'h0);
        chk("rst_m1_gnt", {31'b0, bus_if.m1_gnt}, 32'h0);
        chk("rst_done", {30'b0, bus_if.m0_done, bus_if.m1_done}, 32'h0);
        chk("rst_err", {30'b0, bus_if.m0_err, bus_if.m1_err}, 32'h0);
        chk("rst_m0_rdata", bus_if.m0_rdata, 32'h0);
        chk("rst_m1_rdata", bus_if.m1_rdata, 32'h0);
        chk("rst_addr", data_bus_addr, 32'h0);
        chk("rst_mode", {30'b0, data_bus_mode}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_bus_quiet", {31'b0, bus_quiet()}, 32'h1);

        // Reset mid-ACCESS of an m0 write aborts it
        reset = 1'b1;
        model_en = 1'b0;
        drv_q[0].push_back(mk(32'h0000_40A0, 2'b10, 32'h1234_5678, 0));
        t = 0;
        while (!bus_if.m0_gnt && t < 20) begin @(negedge clk); t++; end
        chk("abort_gnt_seen", {31'b0, bus_if.m0_gnt}, 32'h1);
        chk("abort_in_write_access", {30'b0, data_bus_mode}, 32'h2);
        #2 reset = 1'b0;
        #1;
        chk("abort_m0_gnt", {31'b0, bus_if.m0_gnt}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_mode", {30'b0, data_bus_mode}, 32'h0);
        chk("abort_addr", data_bus_addr, 32'h0);
        chk("abort_bus_quiet", {31'b0, bus_quiet()}, 32'h1);
        repeat (3) @(negedge clk);
        model_en = 1'b1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", {30'b0, bus_if.m0_done, bus_if.m1_done}, 32'h0);
        chk("abort_timer_unchanged", slave_mem[8], init_val(8));

        // m0 write then read of 0x40A4
        drv_q[0].push_back(mk(32'h0000_40A4, 2'b10, 32'h0000_0003, 0));
        drv_q[0].push_back(mk(32'h0000_40A4, 2'b01, 32'h0000_0000, 0));
        wait_done(0, 2, 30, ok);
        chk("wr_rd_done", {31'b0, ok}, 32'h1);
        chk("wr_rd_rdata", bus_if.m0_rdata, 32'h0000_0003);
        chk("wr_rd_err", {31'b0, bus_if.m0_err}, 32'h0);
        chk("wr_rd_m1_idle", {30'b0, bus_if.m1_gnt, bus_if.m1_done}, 32'h0);
        drain();

        // Simultaneous requests: starvation guard ordering
        obs_q.delete();
        for (int k = 0; k < 6; k++) drv_q[0].push_back(mk(32'h0000_4080 + 32'(4 * k), 2'b01, 32'h0, 0));
        for (int k = 0; k < 5; k++) drv_q[1].push_back(mk(32'h0000_4090 + 32'(4 * k), 2'b10, 32'hA000_0000 + 32'(k), 0));
        t = 0;
        while (obs_q.size() < 7 && t < 100) begin @(negedge clk); t++; end
        chk("order_count", 32'(obs_q.size() >= 7), 32'h1);
        for (int k = 0; k < 7; k++) begin
            if (k < obs_q.size()) chk($sformatf("order_%0d", k), 32'(obs_q[k]), 32'(exp_order[k]));
        end
        drain();

        // Illegal mode from m1
        drv_q[1].push_back(mk(32'h0000_40A0, 2'b11, 32'hFFFF_FFFF, 0));
        wait_done(1, 1, 20, ok);
        chk("illegal_done", {31'b0, ok}, 32'h1);
        chk("illegal_err", {31'b0, bus_if.m1_err}, 32'h1);
        drain();
        chk("illegal_timer_unchanged", slave_mem[8], ref_mem[8]);

        // m1 back-to-back reads of 0x40B4
        for (int k = 0; k < 3; k++) drv_q[1].push_back(mk(32'h0000_40B4, 2'b01, 32'h0, 0));
        saw_m0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            ed[k] = -100;
            while (t < 20) begin
                @(negedge clk);
                t++;
                if (bus_if.m0_gnt) saw_m0 = 1'b1;
                if (bus_if.m1_done) begin ed[k] = edge_n; break; end
            end
        end
        chk("b2b_gap_1", 32'(ed[1] - ed[0]), 32'd3);
        chk("b2b_gap_2", 32'(ed[2] - ed[1]), 32'd3);
        chk("b2b_no_m0_gnt", {31'b0, saw_m0}, 32'h0);
        drain();

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (drv_q[i].size() < 2) begin
                    drv_q[i].push_back(mk(32'h0000_4080 + 32'(4 * $urandom_range(0, 15)),
                                          2'($urandom_range(0, 3)), $urandom,
                                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0));
                end
            end
        end
        drain();

        for (int k = 0; k < 16; k++) chk($sformatf("mem_%0d", k), slave_mem[k], ref_mem[k]);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
